// File: rtl/risc16_dmem_arbiter.sv
// Data SRAM arbiter: the RISC16 core data port always wins; host requests wait in a
// one-entry buffer and are issued in the first cycle the core leaves the memory idle.
module risc16_dmem_arbiter #(
    parameter int MEM_AW   = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       cpu_daddr,
    input  logic              cpu_doe,
    input  logic              cpu_dwe,
    input  logic [15:0]       cpu_ddout,
    output logic [15:0]       cpu_ddin,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [15:0]       host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_rvalid,
    output logic [15:0]       host_rdata,
    output logic              host_starve,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [15:0]       mem_rdata
);
    // state    | meaning
    // ST_EMPTY | buffer free, any host request is accepted
    // ST_PEND  | buffer holds a host request waiting for a core-idle cycle
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_PEND  = 1'b1;

    localparam int              WCW      = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]  WAIT_SAT = WCW'(MAX_WAIT);

    logic [0:0]        state;
    logic              buf_we;
    logic [MEM_AW-1:0] buf_addr;
    logic [15:0]       buf_wdata;
    logic [WCW-1:0]    wait_cnt;
    logic [MEM_AW-1:0] last_addr;
    logic [15:0]       last_wdata;

    logic cpu_busy;
    logic cpu_act;
    logic issue;
    logic accept;
    logic unused_addr_bits;

    assign cpu_busy = cpu_doe | cpu_dwe;
    // Core strobes are ignored while reset is held so the SRAM sees no access.
    assign cpu_act  = rst & cpu_busy;
    assign issue    = rst & (state == ST_PEND) & ~cpu_busy;

    // Ready depends only on state and the core strobes, never on host_valid.
    assign host_ready  = rst & ((state == ST_EMPTY) | ~cpu_busy);
    assign accept      = host_valid & host_ready;
    assign host_starve = (wait_cnt >= WAIT_SAT);
    assign cpu_ddin    = mem_rdata;

    assign unused_addr_bits = ^{cpu_daddr[15:MEM_AW+1], cpu_daddr[0],
                                host_addr[15:MEM_AW+1], host_addr[0]};

    always_comb begin
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        mem_addr  = last_addr;
        mem_wdata = last_wdata;
        if (cpu_act) begin
            mem_we    = cpu_dwe;
            mem_oe    = cpu_doe & ~cpu_dwe;
            mem_addr  = cpu_daddr[MEM_AW:1];
            mem_wdata = cpu_ddout;
        end else if (issue) begin
            mem_we    = buf_we;
            mem_oe    = ~buf_we;
            mem_addr  = buf_addr;
            mem_wdata = buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            wait_cnt    <= '0;
            last_addr   <= '0;
            last_wdata  <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            last_addr   <= mem_addr;
            last_wdata  <= mem_wdata;
            host_rvalid <= issue & ~buf_we;
            if (issue && !buf_we) begin
                host_rdata <= mem_rdata;
            end
            if (accept) begin
                state     <= ST_PEND;
                buf_we    <= host_we;
                buf_addr  <= host_addr[MEM_AW:1];
                buf_wdata <= host_wdata;
                wait_cnt  <= '0;
            end else if (issue) begin
                state    <= ST_EMPTY;
                wait_cnt <= '0;
            end else if (state == ST_PEND && wait_cnt != WAIT_SAT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end
endmodule
